snn_debug_probe: RTL and testbench

- Parametrised debug observation block for the SNN core. Selects one membrane potential or one layer's spike vector onto a narrow debug bus.
- Adds four modes over a plain mux:
  - registered live view
  - auto-scan of all channels with a channel tag
  - coherent snapshot of all probed state on a timestep strobe
  - saturating per-layer spike counter
- Sits between the network datapath and the chip's shared debug output pins.

---
 rtl/snn_debug_probe.sv | 124 ++++++++++++
 tb/tb_snn_debug_probe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/snn_debug_probe.sv
// snn_debug_probe: selects one membrane potential, spike layer, snapshot or spike count onto a narrow debug bus
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   en, debug_config_in      config load strobe; [SEL_W-1:0]=sel, [6:5]=mode, [7] ignored
//   sample                   timestep strobe: snapshot capture and spike-count increment
//   membrane_potentials      N_MP flattened potentials of MP_W bits
//   output_spikes            N_LAYERS flattened spike vectors of SPK_W bits
//   debug_output/valid/chan  registered probe data, qualifier and channel index
module snn_debug_probe #(
    parameter int MP_W     = 5,
    parameter int N_MP     = 24,
    parameter int SPK_W    = 8,
    parameter int N_LAYERS = 3,
    parameter int OUT_W    = 8,
    parameter int SEL_W    = 5,
    parameter int SCAN_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [7:0]                debug_config_in,
    input  logic                      sample,
    input  logic [N_MP*MP_W-1:0]      membrane_potentials,
    input  logic [N_LAYERS*SPK_W-1:0] output_spikes,
    output logic [OUT_W-1:0]          debug_output,
    output logic                      debug_valid,
    output logic [SEL_W-1:0]          debug_chan
);
    localparam int N_CH  = N_MP + N_LAYERS;
    localparam int N_TAB = 2 ** SEL_W;
    localparam int DIV_W = $clog2(SCAN_DIV + 1);

    logic [1:0]                mode;
    logic [SEL_W-1:0]          sel;
    logic [N_MP*MP_W-1:0]      snap_mp;
    logic [N_LAYERS*SPK_W-1:0] snap_spk;
    logic                      snap_valid;
    logic [SEL_W-1:0]          scan_idx;
    logic [DIV_W-1:0]          div_cnt;
    logic [OUT_W-1:0]          spike_cnt;
    logic [OUT_W-1:0]          live_tab [N_TAB];
    logic [OUT_W-1:0]          snap_tab [N_TAB];
    logic                      div_zero;
    logic                      div_last;
    logic                      scan_wrap;
    logic [SEL_W-1:0]          cnt_idx;
    logic [OUT_W:0]            cnt_sum;
    logic [OUT_W-1:0]          cnt_next;
    logic                      cfg_unused;

    assign cfg_unused = debug_config_in[7];

    // Every possible index gets a table entry; indices past the last layer alias the last layer.
    genvar c;
    for (c = 0; c < N_TAB; c++) begin : g_map
        if (c < N_MP) begin : g_mp
            assign live_tab[c] = OUT_W'(membrane_potentials[c*MP_W +: MP_W]);
            assign snap_tab[c] = OUT_W'(snap_mp[c*MP_W +: MP_W]);
        end else begin : g_spk
            localparam int L = (c < N_CH) ? c - N_MP : N_LAYERS - 1;
            assign live_tab[c] = OUT_W'(output_spikes[L*SPK_W +: SPK_W]);
            assign snap_tab[c] = OUT_W'(snap_spk[L*SPK_W +: SPK_W]);
        end
    end

    assign div_zero  = div_cnt == '0;
    assign div_last  = div_cnt == DIV_W'(SCAN_DIV - 1);
    assign scan_wrap = scan_idx == SEL_W'(N_CH - 1);
    // A membrane sel counts the last layer, matching the channel-map default.
    assign cnt_idx   = (sel < SEL_W'(N_MP)) ? SEL_W'(N_CH - 1) : sel;
    assign cnt_sum   = {1'b0, spike_cnt} + (OUT_W + 1)'($countones(live_tab[cnt_idx]));
    assign cnt_next  = cnt_sum[OUT_W] ? '1 : cnt_sum[OUT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode       <= '0;
            sel        <= '0;
            snap_mp    <= '0;
            snap_spk   <= '0;
            snap_valid <= 1'b0;
            scan_idx   <= '0;
            div_cnt    <= '0;
            spike_cnt  <= '0;
        end else begin
            if (sample) begin
                snap_mp    <= membrane_potentials;
                snap_spk   <= output_spikes;
                snap_valid <= 1'b1;
            end
            if (en) begin
                mode      <= debug_config_in[6:5];
                sel       <= debug_config_in[SEL_W-1:0];
                scan_idx  <= '0;
                div_cnt   <= '0;
                spike_cnt <= '0;
            end else begin
                if (mode == 2'd1) begin
                    div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
                    if (div_last)
                        scan_idx <= scan_wrap ? '0 : scan_idx + SEL_W'(1);
                end
                if (mode == 2'd3 && sample)
                    spike_cnt <= cnt_next;
            end
        end
    end

    // Scan mode holds data and channel between its one-cycle valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            debug_output <= '0;
            debug_valid  <= 1'b0;
            debug_chan   <= '0;
        end else begin
            debug_valid <= mode == 2'd1 ? div_zero : mode == 2'd2 ? snap_valid : 1'b1;
            if (mode != 2'd1 || div_zero) begin
                debug_output <= mode == 2'd0 ? live_tab[sel] :
                                mode == 2'd1 ? live_tab[scan_idx] :
                                mode == 2'd2 ? snap_tab[sel] : spike_cnt;
                debug_chan   <= mode == 2'd1 ? scan_idx : sel;
            end
        end
    end
endmodule

// File: tb/tb_snn_debug_probe.sv
// tb_snn_debug_probe: randomized scoreboard bench for snn_debug_probe against a behavioural model
module tb_snn_debug_probe;
    localparam int MP_W = 5, N_MP = 24, SPK_W = 8, N_LAYERS = 3;
    localparam int OUT_W = 8, SEL_W = 5, SCAN_DIV = 4, N_CH = N_MP + N_LAYERS;

    typedef struct {int data; int chan;} exp_t;

    logic clk = 0, rst = 1, en = 0, sample = 0;
    logic [7:0] cfg = 0;
    logic [MP_W-1:0] mp [N_MP];
    logic [SPK_W-1:0] spk [N_LAYERS];
    logic [N_MP*MP_W-1:0] mp_flat;
    logic [N_LAYERS*SPK_W-1:0] spk_flat;
    logic [OUT_W-1:0] debug_output;
    logic debug_valid;
    logic [SEL_W-1:0] debug_chan;

    int errors = 0, checks = 0;
    exp_t q[$];
    bit exp_valid = 0;

    int m_mode = 0, m_sel = 0, m_sc = 0, m_cnt = 0;
    bit m_snapv = 0;
    int m_snap_mp [N_MP];
    int m_snap_spk [N_LAYERS];

    always_comb begin
        mp_flat = '0;
        spk_flat = '0;
        for (int i = 0; i < N_MP; i++) mp_flat[i*MP_W +: MP_W] = mp[i];
        for (int j = 0; j < N_LAYERS; j++) spk_flat[j*SPK_W +: SPK_W] = spk[j];
    end

    snn_debug_probe dut (
        .clk(clk), .rst(rst), .en(en), .debug_config_in(cfg), .sample(sample),
        .membrane_potentials(mp_flat), .output_spikes(spk_flat),
        .debug_output(debug_output), .debug_valid(debug_valid), .debug_chan(debug_chan)
    );

    always #5 clk = ~clk;

    function automatic int layer_of(int c);
        return (c >= N_MP && c < N_CH) ? c - N_MP : N_LAYERS - 1;
    endfunction

    function automatic int mapc(int c, bit snap);
        if (c < N_MP) return snap ? m_snap_mp[c] : int'(mp[c]);
        return snap ? m_snap_spk[layer_of(c)] : int'(spk[layer_of(c)]);
    endfunction

    // Reference model: scan position is derived from cycles elapsed since the last load.
    always @(posedge clk or posedge rst) begin
        int ch, d, n;
        bit v;
        if (rst) begin
            m_mode = 0; m_sel = 0; m_sc = 0; m_cnt = 0; m_snapv = 0;
            for (int i = 0; i < N_MP; i++) m_snap_mp[i] = 0;
            for (int j = 0; j < N_LAYERS; j++) m_snap_spk[j] = 0;
            q.delete();
            exp_valid = 0;
        end else begin
            ch = m_sel;
            v = 1;
            case (m_mode)
                0: d = mapc(m_sel, 0);
                1: begin
                    v = (m_sc % SCAN_DIV) == 0;
                    ch = (m_sc / SCAN_DIV) % N_CH;
                    d = mapc(ch, 0);
                end
                2: begin v = m_snapv; d = mapc(m_sel, 1); end
                default: d = m_cnt;
            endcase
            exp_valid = v;
            if (v) q.push_back('{d, ch});
            if (m_mode == 3 && sample && !en) begin
                n = m_cnt + $countones(spk[layer_of(m_sel)]);
                m_cnt = n > 255 ? 255 : n;
            end
            if (m_mode == 1) m_sc++;
            if (sample) begin
                for (int i = 0; i < N_MP; i++) m_snap_mp[i] = int'(mp[i]);
                for (int j = 0; j < N_LAYERS; j++) m_snap_spk[j] = int'(spk[j]);
                m_snapv = 1;
            end
            if (en) begin
                m_mode = int'(cfg[6:5]);
                m_sel = int'(cfg[4:0]);
                m_sc = 0;
                m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            checks++;
            if (debug_valid !== exp_valid) begin
                errors++;
                $display("FAIL valid t=%0t got=%0b want=%0b", $time, debug_valid, exp_valid);
            end
            if (debug_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output t=%0t data=%0h chan=%0d", $time, debug_output, debug_chan);
                end else begin
                    e = q.pop_front();
                    if (debug_output !== OUT_W'(e.data) || debug_chan !== SEL_W'(e.chan)) begin
                        errors++;
                        $display("FAIL data t=%0t got=%0h/ch%0d want=%0h/ch%0d", $time,
                                 debug_output, debug_chan, e.data, e.chan);
                    end
                end
            end else if (exp_valid && q.size() > 0) begin
                void'(q.pop_front());
            end
        end
    end

    task automatic chk(string name, int act, int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [7:0] c);
        en = 1;
        cfg = c;
        step();
        en = 0;
    endtask

    task automatic rnd_inputs();
        for (int i = 0; i < N_MP; i++) mp[i] = MP_W'($urandom);
        for (int j = 0; j < N_LAYERS; j++) spk[j] = SPK_W'($urandom);
    endtask

    initial begin
        for (int i = 0; i < N_MP; i++) mp[i] = '0;
        for (int j = 0; j < N_LAYERS; j++) spk[j] = '0;
        step();
        step();
        chk("reset_output", int'(debug_output), 0);
        chk("reset_valid", int'(debug_valid), 0);
        chk("reset_chan", int'(debug_chan), 0);
        rst = 0;
        step();
        rnd_inputs();
        mp[3] = 5'h15;
        load(8'h03);
        step();
        step();
        spk[1] = 8'hA5;
        load(8'd25);
        step();
        load(8'd31);
        repeat (3) step();
        repeat (30) begin
            rnd_inputs();
            if ($urandom_range(0, 3) == 0) load({3'b000, 5'($urandom_range(0, 31))});
            else step();
        end
        load(8'h20);
        repeat (N_CH * SCAN_DIV + 8) begin
            rnd_inputs();
            step();
        end
        repeat (9) step();
        load(8'hA0);
        repeat (14) begin
            rnd_inputs();
            step();
        end
        load(8'h40);
        repeat (2) step();
        mp[0] = 5'd7;
        sample = 1;
        step();
        sample = 0;
        mp[0] = 5'd9;
        repeat (4) step();
        spk[0] = 8'hFF;
        load(8'h78);
        repeat (40) begin
            sample = 1;
            step();
            sample = 0;
            step();
        end
        repeat (2) step();
        sample = 1;
        load(8'h78);
        sample = 0;
        repeat (3) step();
        repeat (250) begin
            rnd_inputs();
            sample = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 9) == 0) load(8'($urandom));
            else step();
        end
        sample = 0;
        load(8'h20);
        repeat (10) step();
        #1 rst = 1;
        #1;
        chk("async_reset_output", int'(debug_output), 0);
        chk("async_reset_valid", int'(debug_valid), 0);
        chk("async_reset_chan", int'(debug_chan), 0);
        step();
        rst = 0;
        step();
        load(8'h40);
        repeat (3) step();
        load(8'h79);
        repeat (4) begin
            rnd_inputs();
            sample = 1;
            step();
            sample = 0;
            step();
        end
        repeat (2) step();
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
